sha256_core: RTL and testbench
==============================

SHA256_CORE -- requirements
Module: SHA256

Interface
REQ-001 SHALL have: clock  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-003 SHALL have: load_enable  input  1  input_data holds a valid message byte this cycle.
REQ-004 SHALL have: input_complete  input  1  message ends; start padding and hashing.
REQ-005 SHALL have: input_data  input  8  message byte, sent in message order.
REQ-006 SHALL have: hashed_data  output  16  current 16-bit slice of the digest.
REQ-007 SHALL have: out_valid  output  1  hashed_data holds a digest slice.
REQ-008 SHALL have: out_last  output  1  the current slice is the final one (slice 15).

Function
REQ-009 SHALL use states LOAD, PAD, COMPRESS, FINAL, OUTPUT and DONE; reset enters LOAD.
REQ-010 LOAD byte capture SHALL occur on each edge with load_enable=1 and input_complete=0: store byte at index count, then count+1.
REQ-011 count SHALL saturate at 55, so only one block is hashed; bytes after the 55th SHALL be ignored.
REQ-012 input_complete=1 in LOAD SHALL move the FSM to PAD on that edge and SHALL take priority over load_enable; the byte present on that edge SHALL NOT be captured.
REQ-013 PAD (1 cycle) SHALL build a 512-bit block: message bytes, then 0x80, then zeros, then the 64-bit big-endian length count*8 in bits [63:0].
REQ-014 PAD SHALL load W[0..15] from this block and set a..h to the FIPS 180-4 initial values H0..H7 (0x6a09e667 ... 0x5be0cd19).
REQ-015 COMPRESS SHALL run FIPS 180-4 rounds 0..63 at one round per cycle, using the 64-entry K constant table and a 16-word rolling message schedule.
REQ-016 All arithmetic SHALL be modulo 2^32.
REQ-017 FINAL (1 cycle) SHALL form digest Hi = Hi_init + working variable i.
REQ-018 Timing: counting the input_complete edge as edge 0, PAD SHALL end at edge 1, rounds SHALL run on edges 2..65, and FINAL SHALL run on edge 66.
REQ-019 out_valid SHALL first be high after edge 66.
REQ-020 OUTPUT SHALL last 16 cycles, emitting slice k (k=0..15) on cycle k: slice 0 = H0[31:16], slice 1 = H0[15:0], ..., slice 15 = H7[15:0].
REQ-021 out_last SHALL be high only with slice 15.
REQ-022 DONE SHALL force out_valid=0 and out_last=0, hold hashed_data at slice 15, and ignore all inputs until reset.
REQ-023 Outside OUTPUT and DONE, hashed_data SHALL be 0.
REQ-024 load_enable and input_complete SHALL be ignored outside LOAD.
REQ-025 input_complete with count=0 SHALL hash the empty message.

Reset
REQ-026 When reset=0, all outputs SHALL be 0 and count, the block buffer, W, a..h and the digest registers SHALL clear; state SHALL go to LOAD.
REQ-027 Reset in any state (including mid-COMPRESS or mid-OUTPUT) SHALL abort the operation with no partial output afterwards.
REQ-028 After reset is released, a new message SHALL hash correctly.

Configuration
REQ-029 With macro SHA256_UNROLL2_EN defined, COMPRESS SHALL perform two rounds per cycle: rounds on edges 2..33, FINAL on edge 34, out_valid first high after edge 34.
REQ-030 Without SHA256_UNROLL2_EN, one round per cycle SHALL apply (REQ-015, REQ-018, REQ-019).
REQ-031 Digest values and output order SHALL be identical in both builds.

Verification
REQ-032 "Go Irish!": bytes 47 6F 20 49 72 69 73 68 21, one per cycle, then input_complete -> 16 slices 60c9 b396 2375 4d14 4454 fd59 fac8 42d3 80ab 71b8 f824 c3b1 2afd fe46 be40 4e4e, with out_last on 4e4e.
REQ-033 "abc" -> first slices ba78 16bf 8f01 cfea, last slice 15ad; out_valid first high after edge 66, or after edge 34 with SHA256_UNROLL2_EN.
REQ-034 Empty message (input_complete only) -> e3b0 c442 98fc 1c14 ... 7852 b855.
REQ-035 Load 60 bytes of 0x61 -> digest equals the reference-model digest of 55 bytes of 0x61.
REQ-036 Reset asserted at round 30, then "abc" loaded -> no output before the new run; digest correct.
REQ-037 load_enable held high through input_complete and afterwards -> the byte on the complete edge is excluded; DONE holds 4e4e with out_valid=0.

Source files
------------

// File: rtl/sha256_core.sv
// Single-block SHA-256 core: byte loader, padder, round engine, 16-bit digest streamer.
// Define SHA256_UNROLL2_EN to run two compression rounds per clock instead of one.
module sha256_core (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_enable,
    input  logic        input_complete,
    input  logic [7:0]  input_data,
    output logic [15:0] hashed_data,
    output logic        out_valid,
    output logic        out_last
);
    typedef enum logic [2:0] {LOAD, PAD, COMPRESS, FINAL, OUTPUT, DONE} state_t;
    typedef logic [0:7][31:0] wv_t;

    localparam wv_t H_INIT = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

`ifdef SHA256_UNROLL2_EN
    localparam logic [5:0] STEP     = 6'd2;
    localparam logic [5:0] LAST_RND = 6'd62;
`else
    localparam logic [5:0] STEP     = 6'd1;
    localparam logic [5:0] LAST_RND = 6'd63;
`endif

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic wv_t round_f(input wv_t s, input logic [31:0] k, input logic [31:0] wt);
        logic [31:0] t1, t2;
        t1 = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + wt;
        t2 = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
    endfunction

    state_t                 state;
    logic [5:0]             cnt;
    logic [5:0]             rnd;
    logic [3:0]             sidx;
    logic [0:54][7:0]       msg;
    logic [0:15][31:0]      w;
    wv_t                    v;
    logic [0:15][15:0]      dig;

    logic [0:63][7:0]       blk;
    logic [0:15][31:0]      w_nxt;
    wv_t                    v1, v_nxt, dig_sum;

    // Padded block: message, 0x80 marker, zero fill, 64-bit bit length.
    always_comb begin
        blk = '0;
        for (int b = 0; b < 55; b++)
            if (b < int'(cnt)) blk[b] = msg[b];
        blk[cnt]    = 8'h80;
        blk[56:63]  = {55'b0, cnt, 3'b000};
    end

    // Schedule window holds W[t..t+15]; w[0] feeds the current round.
    always_comb begin
        v1 = round_f(v, K[rnd], w[0]);
`ifdef SHA256_UNROLL2_EN
        v_nxt = round_f(v1, K[rnd | 6'd1], w[1]);
        w_nxt = {w[2:15],
                 ssig1(w[14]) + w[9]  + ssig0(w[1]) + w[0],
                 ssig1(w[15]) + w[10] + ssig0(w[2]) + w[1]};
`else
        v_nxt = v1;
        w_nxt = {w[1:15], ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0]};
`endif
        for (int i = 0; i < 8; i++) dig_sum[i] = H_INIT[i] + v[i];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= LOAD;
            cnt         <= '0;
            rnd         <= '0;
            sidx        <= '0;
            msg         <= '0;
            w           <= '0;
            v           <= '0;
            dig         <= '0;
            hashed_data <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (input_complete) begin
                        state <= PAD;
                    end else if (load_enable && cnt != 6'd55) begin
                        msg[cnt] <= input_data;
                        cnt      <= cnt + 6'd1;
                    end
                end
                PAD: begin
                    w     <= blk;
                    v     <= H_INIT;
                    rnd   <= '0;
                    state <= COMPRESS;
                end
                COMPRESS: begin
                    v   <= v_nxt;
                    w   <= w_nxt;
                    rnd <= rnd + STEP;
                    if (rnd == LAST_RND) state <= FINAL;
                end
                FINAL: begin
                    dig         <= dig_sum;
                    sidx        <= '0;
                    hashed_data <= dig_sum[0][31:16];
                    out_valid   <= 1'b1;
                    out_last    <= 1'b0;
                    state       <= OUTPUT;
                end
                OUTPUT: begin
                    if (sidx == 4'd15) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= DONE;
                    end else begin
                        sidx        <= sidx + 4'd1;
                        hashed_data <= dig[sidx + 4'd1];
                        out_last    <= (sidx == 4'd14);
                    end
                end
                DONE: ;
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_core.sv
// Randomized self-checking bench for sha256_core against a plain SHA-256 reference.
module tb_sha256_core;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_enable = 1'b0;
    logic        input_complete = 1'b0;
    logic [7:0]  input_data = 8'h00;
    logic [15:0] hashed_data;
    logic        out_valid;
    logic        out_last;

    int errs = 0;
    int checks = 0;

    logic [7:0] sent_q[$];
    logic [7:0] cap_q[$];

`ifdef SHA256_UNROLL2_EN
    localparam int LAT = 34;
    localparam int RST_E = 17;
`else
    localparam int LAT = 66;
    localparam int RST_E = 32;
`endif

    localparam logic [255:0] GOIRISH = 256'h60c9b39623754d144454fd59fac842d380ab71b8f824c3b12afdfe46be404e4e;
    localparam logic [255:0] ABC     = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY   = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] HI [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    sha256_core dut (
        .clock(clock), .reset(reset), .load_enable(load_enable),
        .input_complete(input_complete), .input_data(input_data),
        .hashed_data(hashed_data), .out_valid(out_valid), .out_last(out_last)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256: pad, expand full 64-word schedule, compress each block.
    function automatic logic [255:0] ref_hash(input logic [7:0] m[$]);
        logic [7:0]  p[$];
        logic [31:0] h[8], s[8], wt[64];
        logic [31:0] t1, t2, s0, s1;
        logic [63:0] bits;
        p = m;
        bits = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        h = HI;
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int t = 0; t < 16; t++)
                wt[t] = {p[64*b+4*t], p[64*b+4*t+1], p[64*b+4*t+2], p[64*b+4*t+3]};
            for (int t = 16; t < 64; t++) begin
                s0 = rotr(wt[t-15], 7) ^ rotr(wt[t-15], 18) ^ (wt[t-15] >> 3);
                s1 = rotr(wt[t-2], 17) ^ rotr(wt[t-2], 19) ^ (wt[t-2] >> 10);
                wt[t] = s1 + wt[t-7] + s0 + wt[t-16];
            end
            s = h;
            for (int t = 0; t < 64; t++) begin
                t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
                     + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + wt[t];
                t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
                     + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
                s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
                s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) h[i] = h[i] + s[i];
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    // Drives sent_q (optionally with idle gaps), then the complete strobe; ends after edge 0.
    task automatic send(input bit hold_le, input bit gaps);
        cap_q.delete();
        foreach (sent_q[i]) begin
            if (gaps) while ($urandom_range(0, 3) == 0) begin
                @(negedge clock); load_enable = 1'b0; input_data = 8'($urandom);
            end
            @(negedge clock); load_enable = 1'b1; input_data = sent_q[i];
            if (cap_q.size() < 55) cap_q.push_back(sent_q[i]);
        end
        @(negedge clock); input_complete = 1'b1; load_enable = hold_le; input_data = 8'h5a;
        @(posedge clock);
        @(negedge clock); input_complete = 1'b0; load_enable = hold_le; input_data = 8'($urandom);
    endtask

    task automatic collect(input string nm, input logic [255:0] exp);
        int e = 0;
        while (!out_valid && e < LAT + 20) begin
            @(posedge clock); e++;
            @(negedge clock); input_data = 8'($urandom);
        end
        chk({nm, "_lat"}, 256'(e), 256'(LAT));
        if (!out_valid) return;
        for (int k = 0; k < 16; k++) begin
            chk({nm, "_slice"}, 256'(hashed_data), 256'(exp[255-16*k -: 16]));
            chk({nm, "_valid"}, 256'(out_valid), 256'(1));
            chk({nm, "_last"}, 256'(out_last), 256'(k == 15));
            @(posedge clock); @(negedge clock);
        end
        chk({nm, "_done_flags"}, 256'({out_valid, out_last}), 256'(0));
        chk({nm, "_done_data"}, 256'(hashed_data), 256'(exp[15:0]));
    endtask

    task automatic do_reset();
        @(negedge clock);
        load_enable = 1'b0; input_complete = 1'b0;
        #2 reset = 1'b0;
        #1 chk("rst_outs", 256'({hashed_data, out_valid, out_last}), 256'(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Mid-operation abort: outputs clear at once and nothing emerges afterwards.
    task automatic abort(input string nm);
        int nv = 0;
        load_enable = 1'b0; input_complete = 1'b0;
        #2 reset = 1'b0;
        #1 chk({nm, "_clr"}, 256'({hashed_data, out_valid, out_last}), 256'(0));
        #10 reset = 1'b1;
        repeat (100) begin
            @(negedge clock);
            if (out_valid || hashed_data != 16'h0) nv++;
        end
        chk({nm, "_quiet"}, 256'(nv), 256'(0));
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_data", 256'(hashed_data), 256'(0));
        chk("reset_valid", 256'(out_valid), 256'(0));
        chk("reset_last", 256'(out_last), 256'(0));
        reset = 1'b1;

        // load_enable held through and past the complete edge
        sent_q = '{8'h47, 8'h6f, 8'h20, 8'h49, 8'h72, 8'h69, 8'h73, 8'h68, 8'h21};
        send(1'b1, 1'b0);
        collect("goirish", GOIRISH);
        repeat (3) begin
            @(negedge clock); input_complete = 1'b1; load_enable = 1'b1; input_data = 8'($urandom);
        end
        @(negedge clock);
        chk("done_hold_data", 256'(hashed_data), 256'(16'h4e4e));
        chk("done_hold_flags", 256'({out_valid, out_last}), 256'(0));

        do_reset();
        sent_q = '{8'h61, 8'h62, 8'h63};
        send(1'b0, 1'b0);
        collect("abc", ABC);

        do_reset();
        sent_q.delete();
        send(1'b0, 1'b0);
        collect("empty", EMPTY);

        do_reset();
        sent_q.delete();
        repeat (60) sent_q.push_back(8'h61);
        send(1'b0, 1'b0);
        collect("a60", ref_hash(cap_q));

        do_reset();
        sent_q = '{8'h61, 8'h62, 8'h63};
        send(1'b0, 1'b0);
        repeat (RST_E) @(posedge clock);
        abort("abort_rnd30");
        send(1'b0, 1'b0);
        collect("abc_after_abort", ABC);

        do_reset();
        sent_q.delete();
        repeat ($urandom_range(1, 40)) sent_q.push_back(8'($urandom));
        send(1'b0, 1'b1);
        begin
            int e = 0;
            while (!out_valid && e < LAT + 20) begin @(negedge clock); e++; end
            chk("abort_out_seen", 256'(out_valid), 256'(1));
        end
        repeat (5) @(negedge clock);
        abort("abort_output");
        sent_q.delete();
        repeat ($urandom_range(0, 55)) sent_q.push_back(8'($urandom));
        send(1'b0, 1'b1);
        collect("after_out_abort", ref_hash(cap_q));

        for (int n = 0; n < 6; n++) begin
            do_reset();
            sent_q.delete();
            repeat ($urandom_range(0, 62)) sent_q.push_back(8'($urandom));
            send(1'($urandom_range(0, 1)), 1'b1);
            collect("rand", ref_hash(cap_q));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
